// File: rtl/pinball_pkg.sv
// Shared definitions for the pinball game controller and its consumers.
// State encodings are also decoded by the audio block, so keep them stable.
package pinball_pkg;

    localparam int unsigned SCORE_W  = 16;
    localparam int unsigned TARGET_W = 4;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned BALLS_W  = 3;
    localparam int unsigned TIMER_W  = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_GET   = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

    // Saturating score add: one extra bit catches the carry instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/pinball_game_ctrl_cycle_timer.sv
// Free-running cycle counter with synchronous clear; expire pulses on the
// last count of each period and the count wraps to zero on that edge.
module cycle_timer
    import pinball_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] limit,
    output logic        expire
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    assign expire = enable && (count_q == (limit - 32'd1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (expire) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pinball_game_ctrl.sv
// Pinball game sequencer: game state, match strobe, score, ball count and
// rotating lit target, all registered.
module pinball_game_ctrl
    import pinball_pkg::*;
#(
    parameter int unsigned BALLS         = 3,
    parameter int unsigned NUM_TARGETS   = 4,
    parameter int unsigned POINTS        = 10,
    parameter int unsigned ROTATE_CYCLES = 50_000_000,
    parameter int unsigned GET_CYCLES    = 200_000_000,
    parameter int unsigned OVER_CYCLES   = 300_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        hit,
    input  logic [3:0]  target_id,
    input  logic        ball_lost,
    output logic [2:0]  state,
    output logic        match,
    output logic [15:0] score,
    output logic [2:0]  balls_left,
    output logic [3:0]  lit_target
);

    game_state_e         state_q, state_d;
    logic                match_q, match_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [BALLS_W-1:0]  balls_q, balls_d;
    logic [TARGET_W-1:0] lit_q,   lit_d;

    logic stmr_clr_c, stmr_en_c, stmr_expire;
    logic rot_clr_c,  rot_en_c,  rot_expire;

    // State timer measures GET and OVER; rotate timer paces the lit target.
    assign stmr_en_c = (state_q == ST_GET) || (state_q == ST_OVER);
    assign rot_en_c  = (state_q == ST_START);

    cycle_timer u_state_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (stmr_clr_c),
        .enable (stmr_en_c),
        .limit  (32'(GET_CYCLES) & {32{state_q == ST_GET}}
                 | 32'(OVER_CYCLES) & {32{state_q != ST_GET}}),
        .expire (stmr_expire)
    );

    cycle_timer u_rotate_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rot_clr_c),
        .enable (rot_en_c),
        .limit  (32'(ROTATE_CYCLES)),
        .expire (rot_expire)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        match_d    = 1'b0;
        score_d    = score_q;
        balls_d    = balls_q;
        lit_d      = lit_q;
        stmr_clr_c = 1'b0;
        rot_clr_c  = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                lit_d = '0;
                if (start_btn) begin
                    state_d   = ST_START;
                    score_d   = '0;
                    balls_d   = BALLS_W'(BALLS);
                    rot_clr_c = 1'b1;
                end
            end
            ST_START: begin
                // Hit compares against the pre-advance lit target.
                if (hit && (target_id == lit_q)) begin
                    match_d = 1'b1;
                    score_d = sat_add(score_q, SCORE_W'(POINTS));
                end
                if (rot_expire) begin
                    lit_d = (lit_q == TARGET_W'(NUM_TARGETS - 1)) ? '0
                                                                  : lit_q + TARGET_W'(1);
                end
                if (ball_lost) begin
                    state_d    = ST_GET;
                    stmr_clr_c = 1'b1;
                end
            end
            ST_GET: begin
                if (stmr_expire) begin
                    if (balls_q > BALLS_W'(1)) begin
                        balls_d   = balls_q - BALLS_W'(1);
                        state_d   = ST_START;
                        rot_clr_c = 1'b1;
                    end else begin
                        balls_d    = '0;
                        state_d    = ST_OVER;
                        stmr_clr_c = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (stmr_expire) begin
                    state_d = ST_WAIT;
                    lit_d   = '0;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            match_q <= 1'b0;
            score_q <= '0;
            balls_q <= '0;
            lit_q   <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            score_q <= score_d;
            balls_q <= balls_d;
            lit_q   <= lit_d;
        end
    end

    assign state      = state_q;
    assign match      = match_q;
    assign score      = score_q;
    assign balls_left = balls_q;
    assign lit_target = lit_q;

endmodule

// File: tb/tb_pinball_game_ctrl.sv
// Scoreboard bench for pinball_game_ctrl: random play against an elapsed-time
// game model, with saturation, coincident-event and async-reset scenarios.
module tb_pinball_game_ctrl;

    localparam int BALLS  = 2;
    localparam int NT     = 4;
    localparam int POINTS = 10;
    localparam int ROT    = 5;
    localparam int GETC   = 8;
    localparam int OVERC  = 12;

    localparam int M_RESET = 0;
    localparam int M_WAIT  = 1;
    localparam int M_START = 2;
    localparam int M_GET   = 3;
    localparam int M_OVER  = 4;

    typedef struct packed {
        logic [2:0]  st;
        logic        m;
        logic [15:0] sc;
        logic [2:0]  bl;
        logic [3:0]  lt;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset, start_btn, hit, ball_lost;
    logic [3:0]  target_id;
    logic [2:0]  state;
    logic        match;
    logic [15:0] score;
    logic [2:0]  balls_left;
    logic [3:0]  lit_target;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference game: counts elapsed cycles in each phase.
    int   m_mode = 0, m_score = 0, m_balls = 0, m_lit = 0, m_tmr = 0, m_rot = 0;
    logic m_match = 1'b0;

    pinball_game_ctrl #(
        .BALLS(BALLS), .NUM_TARGETS(NT), .POINTS(POINTS),
        .ROTATE_CYCLES(ROT), .GET_CYCLES(GETC), .OVER_CYCLES(OVERC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_btn  (start_btn),
        .hit        (hit),
        .target_id  (target_id),
        .ball_lost  (ball_lost),
        .state      (state),
        .match      (match),
        .score      (score),
        .balls_left (balls_left),
        .lit_target (lit_target)
    );

    always #5 clk = ~clk;

    task automatic check_obs(input string name, input obs_t exp);
        obs_t act;
        act = {state, match, score, balls_left, lit_target};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got state=%0d match=%0d score=%0d balls=%0d lit=%0d, expected state=%0d match=%0d score=%0d balls=%0d lit=%0d",
                     name, $time, act.st, act.m, act.sc, act.bl, act.lt,
                     exp.st, exp.m, exp.sc, exp.bl, exp.lt);
        end
    endtask

    task automatic model_step(input logic rst, input logic st, input logic h,
                              input logic [3:0] tid, input logic bl);
        m_match = 1'b0;
        if (rst) begin
            m_mode = M_RESET; m_score = 0; m_balls = 0; m_lit = 0; m_tmr = 0; m_rot = 0;
            return;
        end
        case (m_mode)
            M_RESET: m_mode = M_WAIT;
            M_WAIT: begin
                m_lit = 0;
                if (st) begin
                    m_mode = M_START; m_score = 0; m_balls = BALLS; m_rot = 0;
                end
            end
            M_START: begin
                if (h && int'(tid) == m_lit) begin
                    m_match = 1'b1;
                    m_score = (m_score + POINTS > 65535) ? 65535 : m_score + POINTS;
                end
                m_rot++;
                if (m_rot == ROT) begin
                    m_rot = 0;
                    m_lit = (m_lit + 1) % NT;
                end
                if (bl) begin
                    m_mode = M_GET; m_tmr = 0;
                end
            end
            M_GET: begin
                m_tmr++;
                if (m_tmr == GETC) begin
                    if (m_balls > 1) begin
                        m_balls--; m_mode = M_START; m_rot = 0;
                    end else begin
                        m_balls = 0; m_mode = M_OVER; m_tmr = 0;
                    end
                end
            end
            M_OVER: begin
                m_tmr++;
                if (m_tmr == OVERC) begin
                    m_mode = M_WAIT; m_lit = 0;
                end
            end
            default: ;
        endcase
    endtask

    // Drive one cycle of inputs and queue the outcome expected after the edge.
    task automatic drive(input logic rst, input logic st, input logic h,
                         input logic [3:0] tid, input logic bl);
        @(negedge clk);
        reset = rst; start_btn = st; hit = h; target_id = tid; ball_lost = bl;
        model_step(rst, st, h, tid, bl);
        exp_q.push_back({3'(m_mode), m_match, 16'(m_score), 3'(m_balls), 4'(m_lit)});
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rand_cycle();
        logic rst, st, h, bl;
        logic [3:0] tid;
        rst = ($urandom_range(0, 599) == 0);
        st  = ($urandom_range(0, 7) == 0);
        h   = 1'($urandom_range(0, 1));
        tid = ($urandom_range(0, 1) == 1) ? 4'(m_lit) : 4'($urandom_range(0, 15));
        bl  = ($urandom_range(0, 24) == 0);
        drive(rst, st, h, tid, bl);
    endtask

    task automatic go_wait();
        for (int i = 0; i < 200 && m_mode != M_WAIT; i++)
            drive(1'b0, 1'b0, 1'b0, 4'd0, m_mode == M_START);
    endtask

    // Monitor: every cycle the DUT presents a fresh output tuple.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) check_obs("cycle", exp_q.pop_front());
    end

    initial begin
        reset = 1'b0; start_btn = 1'b0; hit = 1'b0; target_id = 4'd0; ball_lost = 1'b0;
        #1 reset = 1'b1;
        #1 check_obs("reset_state", '0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (3) idle();

        // Random multi-game play.
        for (int i = 0; i < 3000; i++) rand_cycle();

        // Matching hit coinciding with a drained ball.
        go_wait();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (7) idle();
        drive(1'b0, 1'b0, 1'b1, 4'(m_lit), 1'b1);
        for (int i = 0; i < 60; i++) drive(1'b0, 1'b1, 1'b1, 4'(m_lit), 1'b0);
        go_wait();

        // Long ball with near-continuous matching hits drives score to saturation.
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 7500; i++)
            drive(1'b0, ($urandom_range(0, 7) == 0), 1'b1,
                  ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_lit), 1'b0);

        // Async reset in the middle of GET.
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        repeat (3) idle();
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        #1 check_obs("async_reset_mid_get", '0);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (4) idle();

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected tuples left unchecked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pinball_game_ctrl.md
# pinball_game_ctrl

Top-level pinball game sequencer. It turns debounced player and playfield events into the 3-bit game `state` and the one-cycle `match` strobe consumed by the audio block. It also keeps the score, the ball count and the currently lit target for display. It sits directly upstream of the audio block, downstream of the button/sensor debouncers.

## Interface
Parameters:
- `BALLS`, 3: balls per game; valid range 1..7.
- `NUM_TARGETS`, 4: number of playfield targets; valid range 2..16.
- `POINTS`, 10: score added per matching hit.
- `ROTATE_CYCLES`, 50_000_000: clocks between lit-target advances.
- `GET_CYCLES`, 200_000_000: duration of the end-of-ball jingle state.
- `OVER_CYCLES`, 300_000_000: duration of the game-over state.

Ports:
- `clk`  in  1: system clock, 100 MHz.
- `reset`  in  1: asynchronous, active-high.
- `start_btn`  in  1: one-cycle pulse, start request.
- `hit`  in  1: one-cycle pulse, a target was struck.
- `target_id`  in  4: index of the struck target; valid only while `hit`=1.
- `ball_lost`  in  1: one-cycle pulse, ball drained.
- `state`  out  3: game state; encoding RESET=0, WAIT=1, START=2, GET=3, OVER=4.
- `match`  out  1: one-cycle strobe, a hit landed on the lit target.
- `score`  out  16: current score, saturating.
- `balls_left`  out  3: balls remaining, including the ball in play.
- `lit_target`  out  4: index of the currently lit target.

## Operation
- Reset values: `state`=RESET; `match`=0; `score`=0; `balls_left`=0; `lit_target`=0; all timers 0.
- RESET → WAIT unconditionally on the first clock edge after reset deasserts.
- WAIT (attract mode):
  - `lit_target` held at 0.
  - `start_btn` → START. On that edge, `score` loads 0, `balls_left` loads BALLS, `lit_target` loads 0, and the rotate timer clears.
- START (ball in play):
  - The rotate timer counts. When it reaches ROTATE_CYCLES-1 it clears and `lit_target` advances: +1, wrapping from NUM_TARGETS-1 to 0.
  - A `hit` with `target_id`==`lit_target` sets `match`=1 on the next cycle, for exactly 1 cycle.
  - On the same edge, `score` takes `score`+POINTS, clamped at 16'hFFFF.
  - A `hit` on any other target is ignored.
  - `ball_lost` → GET; the state timer clears.
- GET (end-of-ball jingle):
  - `lit_target` frozen; hits and `start_btn` ignored.
  - The state timer expires at GET_CYCLES-1.
  - On expiry with `balls_left`>1: `balls_left` decrements, state → START, rotate timer clears, `lit_target` unchanged.
  - On expiry with `balls_left`==1: `balls_left` → 0, state → OVER, state timer clears.
- OVER:
  - `score` holds the final value; all inputs ignored.
  - On expiry at OVER_CYCLES-1: → WAIT, `lit_target` → 0.
- `start_btn` is ignored in every state except WAIT.
- A `hit` evaluated in START while `ball_lost` is also high in the same cycle:
  - A matching hit is scored and `match` pulses.
  - The state still goes to GET on that edge, so `match` is high during the first GET cycle.
- When a rotate advance and a `hit` coincide, the hit is compared against the pre-advance `lit_target`.
- `ball_lost` outside START is ignored.

## Timing
- All outputs are registered.
- Input-to-output latency is 1 cycle: a sampled pulse affects `state`/`match`/`score` after the next rising edge.
- The state timer is 32 bits. GET lasts exactly GET_CYCLES cycles and OVER lasts exactly OVER_CYCLES cycles, counted from the first cycle in that state.
- `lit_target` changes every ROTATE_CYCLES cycles of continuous START. The rotate timer does not count outside START.
- Asserting `reset` in any state, including mid-timer, returns all outputs to their reset values immediately, without waiting for a clock edge.
- `score` addition is done at 17 bits and saturates; `score` never wraps.

## Structure
- Shared package `pinball_pkg` contains:
  - the state encodings RESET..OVER as 3-bit constants, shared with the audio block;
  - `SCORE_W`=16;
  - `TARGET_W`=4.
- Sub-module `cycle_timer` is instantiated twice, once as the state timer and once as the rotate timer:
  - ports: `clk`, `reset`, `clear`, `enable`, `limit[31:0]`, `expire`;
  - `expire` is combinational, high when count==`limit`-1 and `enable`=1;
  - the count wraps to 0 on expire.
- The controller holds the state register, score, ball and lit-target logic.

## Test plan
Simulation parameters: `BALLS`=2, `NUM_TARGETS`=4, `POINTS`=10, `ROTATE_CYCLES`=5, `GET_CYCLES`=8, `OVER_CYCLES`=12.
1. Release reset → `state`=1 (WAIT) after 1 edge; all other outputs 0. Pulse `start_btn` → `state`=2, `balls_left`=2, `score`=0, `lit_target`=0.
2. Hold START for 12 cycles → `lit_target` steps 0→1→2 at cycles 5 and 10; wraps from 3 back to 0 after 20 cycles.
3. In START, `hit` with `target_id`=`lit_target` → `match`=1 for 1 cycle, `score`=10. `hit` with a wrong id → `match`=0, `score` unchanged. Preload `score`=65530 and score a hit → `score`=65535.
4. Matching `hit` and `ball_lost` in the same cycle → `score`+10; `match`=1 while `state`=3. After 8 cycles → `state`=2, `balls_left`=1.
5. Second `ball_lost` → GET for 8 cycles → OVER with `balls_left`=0 and `score` held. After 12 cycles → WAIT. `start_btn` pulses during GET/OVER have no effect.
6. Assert `reset` mid-GET → outputs go to their reset values without a clock edge. After deassert → RESET → WAIT on the next edge.
